sweep_sequencer: RTL and testbench

Initiator for the offset sampler's run/result handshake. Steps the DUT signal select through a programmed arithmetic sweep and issues one `request_run` per point. Captures each `result_ready`/`result` pair, tagged with its select value, into a show-ahead FIFO that the host reads over the SPI register bridge. Sits between the SPI register file and the sampler, in the sampler's `clk` domain.

---
 rtl/sweep_sequencer_pkg.sv | 14 +
 rtl/sweep_sequencer_if.sv | 11 +
 rtl/sweep_sequencer_result_fifo.sv | 37 +++
 rtl/sweep_sequencer.sv | 111 +++++++++++
 tb/tb_sweep_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sweep_sequencer_pkg.sv
// sampler_pkg: state encoding and result-entry layout shared by the sweep sequencer.
package sampler_pkg;
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ARM         = 3'd1;
    localparam logic [2:0] S_REQUEST     = 3'd2;
    localparam logic [2:0] S_WAIT_RESULT = 3'd3;
    localparam logic [2:0] S_STORE       = 3'd4;
    localparam logic [2:0] S_DRAIN       = 3'd5;
    localparam int ENTRY_W = 64;
    localparam int SEL_W   = 32;
    localparam int RES_W   = 32;
    localparam int SEL_LSB = 32;
    localparam int RES_LSB = 0;
endpackage

// File: rtl/sweep_sequencer_if.sv
// sweep_sequencer_if: run/result handshake between the sequencer (master) and the sampler (slave).
interface sweep_sequencer_if;
    import sampler_pkg::*;
    logic             request_run;
    logic [SEL_W-1:0] dut_signal_select;
    logic             sampler_running;
    logic             sampler_result_ready;
    logic [RES_W-1:0] sampler_result;
    modport master (output request_run, dut_signal_select, input sampler_running, sampler_result_ready, sampler_result);
    modport slave  (input request_run, dut_signal_select, output sampler_running, sampler_result_ready, sampler_result);
endinterface

// File: rtl/sweep_sequencer_result_fifo.sv
// result_fifo: show-ahead FIFO; head entry is always visible on dout, pops while empty are ignored.
module result_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            din,
    input  logic                        pop,
    output logic [WIDTH-1:0]            dout,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop  = pop && count != '0;
    assign do_push = push && count != FULL;
    assign dout    = mem[rd_ptr];
    assign empty   = count == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: steps the sampler's signal select through an arithmetic sweep,
// one run per point, and buffers {select, result} entries for the host.
module sweep_sequencer
    import sampler_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [31:0]                 sweep_first,
    input  logic [31:0]                 sweep_step,
    input  logic [31:0]                 sweep_count,
    sweep_sequencer_if.master           smp,
    input  logic                        fifo_rd_en,
    output logic [ENTRY_W-1:0]          fifo_rd_data,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    logic [2:0] state;
    logic [31:0] step, count, idx;
    logic [SEL_W-1:0] sel;
    logic [RES_W-1:0] res;
    logic req;
    logic [ENTRY_W-1:0] entry;
    always_comb begin
        entry = '0;
        entry[SEL_LSB +: SEL_W] = sel;
        entry[RES_LSB +: RES_W] = res;
    end
    assign smp.request_run       = req;
    assign smp.dut_signal_select = sel;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            step  <= '0;
            count <= '0;
            idx   <= '0;
            sel   <= '0;
            res   <= '0;
            req   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    step  <= sweep_step;
                    count <= sweep_count;
                    idx   <= '0;
                    sel   <= sweep_first;
                    if (sweep_count == '0) done <= 1'b1;
                    else begin
                        state <= S_ARM;
                        busy  <= 1'b1;
                    end
                end
                // Holding here while full is what guarantees no entry is ever dropped.
                S_ARM: if (abort) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if (fifo_count < FULL && !smp.sampler_running) begin
                    req   <= 1'b1;
                    state <= S_REQUEST;
                end
                S_REQUEST: if (abort || smp.sampler_running) begin
                    req   <= 1'b0;
                    state <= abort ? S_DRAIN : S_WAIT_RESULT;
                end
                S_WAIT_RESULT: if (abort) state <= S_DRAIN;
                else if (smp.sampler_result_ready) begin
                    res   <= smp.sampler_result;
                    state <= S_STORE;
                end
                S_STORE: begin
                    idx <= idx + 32'd1;
                    if (abort || idx + 32'd1 == count) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        sel   <= sel + step;
                        state <= S_ARM;
                    end
                end
                S_DRAIN: if (smp.sampler_result_ready || !smp.sampler_running) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    result_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (state == S_STORE),
        .din   (entry),
        .pop   (fifo_rd_en),
        .dout  (fifo_rd_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: directed scenarios against a behavioural sampler returning select*2.
module tb_sweep_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, rd_en = 1'b0;
    logic [31:0] first = '0, step = '0, cnt = '0;
    logic [63:0] rd_data;
    logic empty, busy, done;
    logic [2:0] fcount;
    int tests = 0, fails = 0;
    int done_cnt = 0, req_cnt = 0;
    logic m_run, m_rdy;
    logic [31:0] m_res;
    int m_cnt;

    sweep_sequencer_if s ();

    sweep_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .sweep_first  (first),
        .sweep_step   (step),
        .sweep_count  (cnt),
        .smp          (s.master),
        .fifo_rd_en   (rd_en),
        .fifo_rd_data (rd_data),
        .fifo_empty   (empty),
        .fifo_count   (fcount),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Sampler model: starts on request_run, runs 4 cycles, pulses ready with select*2 as running drops.
    assign s.sampler_running      = m_run;
    assign s.sampler_result_ready = m_rdy;
    assign s.sampler_result       = m_res;
    always @(posedge clk or negedge m_rst_n) begin
        if (!m_rst_n) begin
            m_run <= 1'b0; m_rdy <= 1'b0; m_res <= '0; m_cnt <= 0;
        end else begin
            m_rdy <= 1'b0;
            if (m_run) begin
                if (m_cnt == 0) begin
                    m_run <= 1'b0; m_rdy <= 1'b1; m_res <= s.dut_signal_select << 1;
                end else m_cnt <= m_cnt - 1;
            end else if (s.request_run) begin
                m_run <= 1'b1; m_cnt <= 3;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (s.request_run) req_cnt++;
    end

    task automatic pulse_start(input logic [31:0] f, input logic [31:0] st, input logic [31:0] c);
        @(negedge clk);
        first = f; step = st; cnt = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max && !ok; k++) begin
            if (done) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic pop_expect(input string name, input logic [63:0] exp);
        tests++;
        if (rd_data !== exp) begin
            fails++;
            $display("FAIL %s: rd_data=%h expected %h", name, rd_data, exp);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if (s.request_run !== 1'b0 || s.dut_signal_select !== 32'd0 || busy !== 1'b0 || done !== 1'b0 ||
            empty !== 1'b1 || fcount !== 3'd0 || rd_data !== 64'd0) begin
            fails++;
            $display("FAIL %s: req=%b sel=%h busy=%b done=%b empty=%b count=%0d data=%h expected 0,0,0,0,1,0,0",
                     name, s.request_run, s.dut_signal_select, busy, done, empty, fcount, rd_data);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; m_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        rst_n = 1'b1; m_rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset_release");
    endtask

    task automatic test_sweep;
        bit ok;
        done_cnt = 0;
        pulse_start(32'd5, 32'd3, 32'd4);
        tests++;
        if (busy !== 1'b1 || s.request_run !== 1'b0 || s.dut_signal_select !== 32'd5) begin
            fails++;
            $display("FAIL sweep_arm: busy=%b req=%b sel=%h expected 1,0,5", busy, s.request_run, s.dut_signal_select);
        end
        @(negedge clk);
        tests++;
        if (s.request_run !== 1'b1) begin
            fails++;
            $display("FAIL sweep_req_latency: req=%b expected 1", s.request_run);
        end
        pulse_start(32'd100, 32'd7, 32'd2);
        wait_done(200, ok);
        tests++;
        if (!ok || busy !== 1'b0) begin
            fails++;
            $display("FAIL sweep_done: seen=%b busy=%b expected 1,0", ok, busy);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (fcount !== 3'd4 || done_cnt !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL sweep_count: count=%0d dones=%0d busy=%b expected 4,1,0", fcount, done_cnt, busy);
        end
        pop_expect("sweep_e0", {32'd5, 32'd10});
        pop_expect("sweep_e1", {32'd8, 32'd16});
        pop_expect("sweep_e2", {32'd11, 32'd22});
        pop_expect("sweep_e3", {32'd14, 32'd28});
        tests++;
        if (empty !== 1'b1 || fcount !== 3'd0) begin
            fails++;
            $display("FAIL sweep_drained: empty=%b count=%0d expected 1,0", empty, fcount);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        pulse_start(32'hFFFF_FFFE, 32'd1, 32'd3);
        wait_done(200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wrap_done: seen=0 expected 1");
        end
        @(negedge clk);
        tests++;
        if (fcount !== 3'd3) begin
            fails++;
            $display("FAIL wrap_count: count=%0d expected 3", fcount);
        end
        pop_expect("wrap_e0", {32'hFFFF_FFFE, 32'hFFFF_FFFC});
        pop_expect("wrap_e1", {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        pop_expect("wrap_e2", {32'h0000_0000, 32'h0000_0000});
    endtask

    task automatic test_stall;
        bit ok;
        pulse_start(32'd1, 32'd1, 32'd6);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (fcount == 3'd4) ok = 1'b1;
            else @(negedge clk);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (!ok || fcount !== 3'd4 || s.request_run !== 1'b0 || busy !== 1'b1 || m_run !== 1'b0) begin
            fails++;
            $display("FAIL stall_full: reached=%b count=%0d req=%b busy=%b run=%b expected 1,4,0,1,0",
                     ok, fcount, s.request_run, busy, m_run);
        end
        pop_expect("stall_e0", {32'd1, 32'd2});
        pop_expect("stall_e1", {32'd2, 32'd4});
        wait_done(200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_done: seen=0 expected 1");
        end
        @(negedge clk);
        tests++;
        if (fcount !== 3'd4) begin
            fails++;
            $display("FAIL stall_count: count=%0d expected 4", fcount);
        end
        pop_expect("stall_e2", {32'd3, 32'd6});
        pop_expect("stall_e3", {32'd4, 32'd8});
        pop_expect("stall_e4", {32'd5, 32'd10});
        pop_expect("stall_e5", {32'd6, 32'd12});
    endtask

    task automatic test_abort;
        bit ok;
        done_cnt = 0;
        pulse_start(32'd10, 32'd1, 32'd5);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (fcount == 3'd1 && m_run && !s.request_run) ok = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL abort_reach_wait: reached=0 expected 1");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (m_rdy) ok = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (!ok || done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_drain: ready=%b done=%b busy=%b expected 1,0,1", ok, done, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_done: done=%b busy=%b expected 1,0", done, busy);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (fcount !== 3'd1 || done_cnt !== 1 || req_cnt == 0) begin
            fails++;
            $display("FAIL abort_entries: count=%0d dones=%0d expected 1,1", fcount, done_cnt);
        end
        pop_expect("abort_e0", {32'd10, 32'd20});
    endtask

    task automatic test_zero;
        done_cnt = 0; req_cnt = 0;
        pulse_start(32'd9, 32'd1, 32'd0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: done=%b busy=%b expected 1,0", done, busy);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt !== 1 || req_cnt !== 0 || fcount !== 3'd0) begin
            fails++;
            $display("FAIL zero_quiet: dones=%0d reqs=%0d count=%0d expected 1,0,0", done_cnt, req_cnt, fcount);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        pulse_start(32'd7, 32'd2, 32'd3);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (s.request_run && m_run) ok = 1'b1;
            else @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rstmid_reach: reached=0 expected 1");
        end
        check_reset_values("rstmid_values");
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (!m_run) ok = 1'b1;
            else @(negedge clk);
        end
        pulse_start(32'd7, 32'd2, 32'd2);
        wait_done(200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rstmid_done: seen=0 expected 1");
        end
        @(negedge clk);
        tests++;
        if (fcount !== 3'd2) begin
            fails++;
            $display("FAIL rstmid_count: count=%0d expected 2", fcount);
        end
        pop_expect("rstmid_e0", {32'd7, 32'd14});
        pop_expect("rstmid_e1", {32'd9, 32'd18});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        tests++;
        if (fcount !== 3'd0 || empty !== 1'b1 || rd_data !== 64'd0) begin
            fails++;
            $display("FAIL empty_pop: count=%0d empty=%b data=%h expected 0,1,0", fcount, empty, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_wrap();
        test_stall();
        test_abort();
        test_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
